// File: rtl/logic_gate_array_pkg.sv
// Shared types and the gate truth function for the logic gate array.
package logic_gate_pkg;

    // Gate function codes, matching the 74xx family a channel emulates.
    typedef enum logic [2:0] {
        FN_AND  = 3'd0,
        FN_OR   = 3'd1,
        FN_NAND = 3'd2,
        FN_NOR  = 3'd3,
        FN_XOR  = 3'd4,
        FN_XNOR = 3'd5,
        FN_BUF  = 3'd6,
        FN_INV  = 3'd7
    } func_e;

    // Per-channel inertial-delay state.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_e;

    // Ideal (zero-delay) gate output for a function code; BUF/INV ignore b.
    function automatic logic gate_eval(input func_e f, input logic a, input logic b);
        logic r;
        case (f)
            FN_AND:  r = a & b;
            FN_OR:   r = a | b;
            FN_NAND: r = ~(a & b);
            FN_NOR:  r = ~(a | b);
            FN_XOR:  r = a ^ b;
            FN_XNOR: r = ~(a ^ b);
            FN_BUF:  r = a;
            FN_INV:  r = ~a;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_gate_array_channel.sv
// One emulated 2-input gate: input sampling, run-time function/delay,
// and an inertial-delay FSM that swallows target pulses shorter than delay+1.
module gate_channel
    import logic_gate_pkg::*;
#(
    parameter int         DELAY_W       = 4,
    parameter logic [2:0] DEFAULT_FUNC  = 3'd1,
    parameter int         DEFAULT_DELAY = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               a,
    input  logic               b,
    input  logic               cfg_en,
    input  logic [2:0]         cfg_func,
    input  logic [DELAY_W-1:0] cfg_delay,
    output logic               y,
    output logic               busy
);

    logic               a_q, a_d;
    logic               b_q, b_d;
    func_e              func_q, func_d;
    logic [DELAY_W-1:0] delay_q, delay_d;
    logic [DELAY_W-1:0] cnt_q, cnt_d;
    state_e             state_q, state_d;
    logic               y_q, y_d;
    logic               target;

    // Target is what the ideal gate would show for the sampled inputs.
    assign target = gate_eval(func_q, a_q, b_q);

    // Sample inputs every edge; a config write lands after this edge's evaluation.
    always_comb begin
        a_d     = a;
        b_d     = b;
        func_d  = func_q;
        delay_d = delay_q;
        if (cfg_en) begin
            func_d  = func_e'(cfg_func);
            delay_d = cfg_delay;
        end
    end

    // Inertial delay: a mismatch must persist delay+1 evaluations to reach y.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        case (state_q)
            ST_IDLE: begin
                if (target != y_q) begin
                    if (delay_q == '0) begin
                        y_d = target;
                    end else begin
                        cnt_d   = delay_q - DELAY_W'(1);
                        state_d = ST_PEND;
                    end
                end
            end
            ST_PEND: begin
                if (target == y_q) begin
                    // Target returned before the delay expired: drop the glitch.
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    y_d     = target;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - DELAY_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // All channel state; reset discards any pending transition at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            func_q  <= func_e'(DEFAULT_FUNC);
            delay_q <= DELAY_W'(DEFAULT_DELAY);
            cnt_q   <= '0;
            state_q <= ST_IDLE;
            y_q     <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            func_q  <= func_d;
            delay_q <= delay_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            y_q     <= y_d;
        end
    end

    // Outputs come straight from flops.
    always_comb begin
        y    = y_q;
        busy = (state_q == ST_PEND);
    end

endmodule

// File: rtl/logic_gate_array.sv
// Array of independent run-time configurable gates with inertial delay.
module logic_gate_array
    import logic_gate_pkg::*;
#(
    parameter int         CHANNELS      = 4,
    parameter int         DELAY_W       = 4,
    parameter logic [2:0] DEFAULT_FUNC  = 3'd1,
    parameter int         DEFAULT_DELAY = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] a,
    input  logic [CHANNELS-1:0] b,
    input  logic                cfg_we,
    input  logic [3:0]          cfg_ch,
    input  logic [2:0]          cfg_func,
    input  logic [DELAY_W-1:0]  cfg_delay,
    output logic [CHANNELS-1:0] y,
    output logic [CHANNELS-1:0] busy
);

    logic [CHANNELS-1:0] cfg_en;

    // Indices at or above CHANNELS match no channel, so such writes vanish.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        assign cfg_en[g] = cfg_we && (cfg_ch == 4'(g));

        gate_channel #(
            .DELAY_W      (DELAY_W),
            .DEFAULT_FUNC (DEFAULT_FUNC),
            .DEFAULT_DELAY(DEFAULT_DELAY)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .a        (a[g]),
            .b        (b[g]),
            .cfg_en   (cfg_en[g]),
            .cfg_func (cfg_func),
            .cfg_delay(cfg_delay),
            .y        (y[g]),
            .busy     (busy[g])
        );
    end

endmodule

// File: tb/tb_logic_gate_array.sv
// Bench for logic_gate_array: directed scenarios plus random traffic, all
// checked every cycle against a mismatch-streak model of inertial delay.
module tb_logic_gate_array;

    localparam int CH = 4;
    localparam int DW = 4;

    logic          clk;
    logic          rst_n;
    logic [CH-1:0] a, b;
    logic          cfg_we;
    logic [3:0]    cfg_ch;
    logic [2:0]    cfg_func;
    logic [DW-1:0] cfg_delay;
    logic [CH-1:0] y, busy;

    int tests = 0;
    int fails = 0;

    logic_gate_array #(
        .CHANNELS(CH), .DELAY_W(DW), .DEFAULT_FUNC(3'd1), .DEFAULT_DELAY(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_func(cfg_func), .cfg_delay(cfg_delay), .y(y), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // A channel's output flips once the ideal gate has disagreed with it for
    // (delay latched at the start of the streak)+1 consecutive edges.
    bit [CH-1:0] m_y, m_aq, m_bq;
    int          m_run   [CH];
    int          m_dl    [CH];
    int          m_func  [CH];
    int          m_delay [CH];
    bit          mt;

    function automatic bit ideal(input int f, input bit x, input bit z);
        case (f)
            0: return x & z;
            1: return x | z;
            2: return !(x & z);
            3: return !(x | z);
            4: return x ^ z;
            5: return x == z;
            6: return x;
            default: return !x;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_y  = '0;
            m_aq = '0;
            m_bq = '0;
            for (int i = 0; i < CH; i++) begin
                m_run[i] = 0; m_dl[i] = 0; m_func[i] = 1; m_delay[i] = 0;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                mt = ideal(m_func[i], m_aq[i], m_bq[i]);
                if (mt == m_y[i]) begin
                    m_run[i] = 0;
                end else begin
                    if (m_run[i] == 0) m_dl[i] = m_delay[i];
                    if (m_run[i] == m_dl[i]) begin
                        m_y[i]   = mt;
                        m_run[i] = 0;
                    end else begin
                        m_run[i] = m_run[i] + 1;
                    end
                end
            end
            m_aq = a;
            m_bq = b;
            if (cfg_we && cfg_ch < CH) begin
                m_func[int'(cfg_ch)]  = int'(cfg_func);
                m_delay[int'(cfg_ch)] = int'(cfg_delay);
            end
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        logic [CH-1:0] mb;
        for (int i = 0; i < CH; i++) mb[i] = (m_run[i] != 0);
        tests++;
        if (y !== m_y || busy !== mb) begin
            fails++;
            $display("FAIL model t=%0t y=%b busy=%b expected y=%b busy=%b",
                     $time, y, busy, m_y, mb);
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cfg_write(input logic [3:0] ch, input logic [2:0] f, input logic [DW-1:0] d);
        cfg_we = 1'b1; cfg_ch = ch; cfg_func = f; cfg_delay = d;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int bcnt;
        bit saw;
        logic [CH-1:0] am, bm;

        rst_n = 1'b0; a = '0; b = '0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_func = '0; cfg_delay = '0;
        tick(2);
        chk("reset_y", 32'(y), 0);
        chk("reset_busy", 32'(busy), 0);
        rst_n = 1'b1;
        tick(3);

        // OR sweep on ch0, delay 0: y lands 2 edges after the input change.
        for (int p = 0; p < 4; p++) begin
            logic exp_y;
            a[0] = p[1]; b[0] = p[0];
            exp_y = p[1] | p[0];
            tick(1);
            if (p == 1) chk("sweep01_edge1", 32'(y[0]), 0);
            tick(1);
            chk($sformatf("sweep%0d_y", p), 32'(y[0]), 32'(exp_y));
            chk($sformatf("sweep%0d_busy", p), 32'(busy[0]), 0);
            tick(8);
        end
        a[0] = 1'b0; b[0] = 1'b0;

        // ch1 NAND with delay 3; idle at a=b=0 so y[1] rises first.
        cfg_write(4'd1, 3'd2, 4'd3);
        tick(1);
        cfg_we = 1'b0;
        tick(9);
        chk("nand_settle_y1", 32'(y[1]), 1);
        a[1] = 1'b1; b[1] = 1'b1;
        bcnt = 0;
        for (int j = 1; j <= 5; j++) begin
            tick(1);
            if (busy[1]) bcnt++;
            if (j == 4) chk("nand_y1_before", 32'(y[1]), 1);
            if (j == 5) chk("nand_y1_fall", 32'(y[1]), 0);
        end
        chk("nand_busy_cycles", 32'(bcnt), 3);

        // Short pulse (2 cycles) on the target is swallowed.
        tick(3);
        b[1] = 1'b0; saw = 0; bcnt = 0;
        for (int j = 0; j < 12; j++) begin
            if (j == 2) b[1] = 1'b1;
            tick(1);
            if (y[1]) saw = 1;
            if (busy[1]) bcnt++;
        end
        chk("glitch2_y_never", 32'(saw), 0);
        chk("glitch2_busy_seen", 32'(bcnt != 0), 1);

        // 4-cycle pulse passes and returns.
        b[1] = 1'b0; saw = 0;
        for (int j = 0; j < 16; j++) begin
            if (j == 4) b[1] = 1'b1;
            tick(1);
            if (y[1]) saw = 1;
        end
        chk("pulse4_y_seen", 32'(saw), 1);
        chk("pulse4_y_back", 32'(y[1]), 0);

        // Reset, then NOR on ch2 written at the first edge.
        rst_n = 1'b0;
        tick(1);
        chk("rst2_y", 32'(y), 0);
        a = '0; b = '0;
        cfg_write(4'd2, 3'd3, 4'd0);
        rst_n = 1'b1;
        tick(1);
        chk("nor_edge1_y2", 32'(y[2]), 0);
        cfg_we = 1'b0;
        tick(1);
        chk("nor_edge2_y2", 32'(y[2]), 1);

        // Out-of-range channel write must not alias onto any channel.
        cfg_write(4'd15, 3'd7, 4'd0);
        tick(1);
        cfg_we = 1'b0;
        tick(3);
        chk("ch15_ignored", 32'(y), 32'h4);

        // ch3: get y=1, then set delay 3 and start a falling transition.
        a[3] = 1'b1;
        tick(3);
        chk("ch3_high", 32'(y[3]), 1);
        cfg_write(4'd3, 3'd1, 4'd3);
        tick(1);
        cfg_we = 1'b0;
        a[3] = 1'b0;
        tick(2);
        chk("ch3_pend_busy", 32'(busy[3]), 1);
        chk("ch3_pend_y", 32'(y[3]), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_y3", 32'(y[3]), 0);
        chk("async_rst_busy3", 32'(busy[3]), 0);
        tick(1);
        rst_n = 1'b1;
        tick(2);

        // XOR write on ch0 in the same edge as the input change.
        a[0] = 1'b1; b[0] = 1'b0;
        cfg_write(4'd0, 3'd4, 4'd0);
        tick(1);
        cfg_we = 1'b0;
        chk("xor_write_edge_y0", 32'(y[0]), 0);
        tick(1);
        chk("xor_next_edge_y0", 32'(y[0]), 1);
        tick(3);
        chk("xor_final_y0", 32'(y[0]), 1);

        // Random traffic, checked by the model every cycle.
        for (int c = 0; c < 3000; c++) begin
            am = '0; bm = '0;
            for (int i = 0; i < CH; i++) begin
                am[i] = ($urandom_range(0, 7) == 0);
                bm[i] = ($urandom_range(0, 7) == 0);
            end
            a = a ^ am;
            b = b ^ bm;
            if ($urandom_range(0, 15) == 0)
                cfg_write(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                          DW'($urandom_range(0, 5)));
            else
                cfg_we = 1'b0;
            if ($urandom_range(0, 399) == 0) begin
                #3 rst_n = 1'b0;
                #4 rst_n = 1'b1;
            end
            tick(1);
        end
        cfg_we = 1'b0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
